// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions used by the fetch stage.
// Holds the fetch FSM encoding and the instruction-size constant.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_VALID = 2'd2,
        FS_ERROR = 2'd3
    } fetch_state_e;

    localparam logic [31:0] INSTR_SIZE = 32'd4;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one memory read per
// instruction and presents the word to decode via valid/ready.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] next_pc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        fetch_err,
    output logic [31:0] fetch_count
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  count_q, count_d;
    logic         xfer;

    assign xfer = (state_q == FS_VALID) && instr_ready;

    // Next-state, PC, instruction and counter updates.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
        unique case (state_q)
            FS_IDLE: begin
                state_d = FS_FETCH;
            end
            FS_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = FS_VALID;
                end
            end
            FS_VALID: begin
                if (xfer) begin
                    pc_d    = next_pc;
                    count_d = count_q + 32'd1;
                    if (is_word_aligned(next_pc)) begin
                        state_d = FS_FETCH;
                    end else begin
                        state_d = FS_ERROR;
                    end
                end
            end
            FS_ERROR: begin
                state_d = FS_ERROR;
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase
    end

    // FSM and PC registers; reset abandons any fetch in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FS_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
        end
    end

    assign pc          = pc_q;
    assign pc_plus     = pc_q + INSTR_SIZE;
    assign imem_req    = (state_q == FS_FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == FS_VALID);
    assign fetch_err   = (state_q == FS_ERROR);
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
// Inputs change 1ns after the rising edge; outputs sampled there too.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] next_pc;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        fetch_err;
    logic [31:0] fetch_count;

    int checks = 0;
    int failures = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .next_pc    (next_pc),
        .pc         (pc),
        .pc_plus    (pc_plus),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .fetch_err  (fetch_err),
        .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        next_pc     = 32'd0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        instr_ready = 1'b0;

        // Reset values, with a stray ack that must be discarded
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        step();
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_err", {31'd0, fetch_err}, 32'd0);
        check("rst_count", fetch_count, 32'd0);
        imem_ack = 1'b0;

        // First fetch: IDLE -> FETCH, ack in second cycle
        rst_n = 1'b1;
        step();
        check("f0_req", {31'd0, imem_req}, 32'd1);
        check("f0_addr", imem_addr, 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h2008_0005;
        step();
        imem_ack = 1'b0;
        check("f0_instr", instr, 32'h2008_0005);
        check("f0_valid", {31'd0, instr_valid}, 32'd1);
        check("f0_pcplus", pc_plus, 32'h4);
        check("f0_req_off", {31'd0, imem_req}, 32'd0);

        // Sequential walk with ready held high
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("seq_pc", pc, 32'(4 * i));
            next_pc = pc_plus;
            step();
            check("seq_valid_drop", {31'd0, instr_valid}, 32'd0);
            check("seq_addr", imem_addr, 32'(4 * i + 4));
            check("seq_count", fetch_count, 32'(i + 1));
            imem_ack   = 1'b1;
            imem_rdata = 32'h1000_0000 + 32'(i);
            step();
            imem_ack = 1'b0;
            check("seq_instr", instr, 32'h1000_0000 + 32'(i));
            check("seq_count_hold", fetch_count, 32'(i + 1));
        end
        check("seq_pc_end", pc, 32'h10);

        // Accept, then ack delayed 3 cycles
        next_pc = 32'h14;
        step();
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("dly_req", {31'd0, imem_req}, 32'd1);
            check("dly_addr", imem_addr, 32'h14);
            check("dly_valid", {31'd0, instr_valid}, 32'd0);
            step();
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'hAAAA_0001;
        step();
        check("dly_valid_up", {31'd0, instr_valid}, 32'd1);
        check("dly_instr", instr, 32'hAAAA_0001);

        // Stall for 5 cycles in VALID; ack there must be ignored
        imem_rdata = 32'h5555_5555;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_instr", instr, 32'hAAAA_0001);
            check("stall_pc", pc, 32'h14);
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        next_pc     = 32'h40;
        step();
        instr_ready = 1'b0;
        check("jmp_addr", imem_addr, 32'h40);
        check("jmp_count", fetch_count, 32'd6);
        imem_ack   = 1'b1;
        imem_rdata = 32'hBBBB_0002;
        step();
        imem_ack = 1'b0;
        check("jmp_instr", instr, 32'hBBBB_0002);

        // Misaligned target -> sticky error
        instr_ready = 1'b1;
        next_pc     = 32'h42;
        step();
        check("err_flag", {31'd0, fetch_err}, 32'd1);
        check("err_pc", pc, 32'h42);
        check("err_count", fetch_count, 32'd7);
        imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("err_req", {31'd0, imem_req}, 32'd0);
            check("err_valid", {31'd0, instr_valid}, 32'd0);
            check("err_sticky", {31'd0, fetch_err}, 32'd1);
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        rst_n       = 1'b0;
        #1;
        check("err_rst_pc", pc, 32'h0);
        check("err_rst_flag", {31'd0, fetch_err}, 32'd0);
        check("err_rst_count", fetch_count, 32'd0);

        // Reset during FETCH with ack in the same cycle
        step();
        rst_n = 1'b1;
        step();
        check("rf_req", {31'd0, imem_req}, 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = 32'hCCCC_0003;
        #2;
        rst_n = 1'b0;
        step();
        check("rf_valid", {31'd0, instr_valid}, 32'd0);
        check("rf_pc", pc, 32'h0);
        check("rf_count", fetch_count, 32'd0);
        check("rf_instr", instr, 32'h0);
        imem_ack = 1'b0;

        // pc_plus wraps at the top of the address space
        rst_n = 1'b1;
        step();
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0013;
        step();
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        next_pc     = 32'hFFFF_FFFC;
        step();
        instr_ready = 1'b0;
        check("wrap_pc", pc, 32'hFFFF_FFFC);
        check("wrap_pcplus", pc_plus, 32'h0);
        check("wrap_req", {31'd0, imem_req}, 32'd1);
        check("wrap_count", fetch_count, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset; word-aligned.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 next_pc  input  32  address of the next instruction, from the next-PC logic.
REQ-005 pc  output  32  address of the instruction being fetched or presented.
REQ-006 pc_plus  output  32  pc + 4, combinational, feeds next-PC logic.
REQ-007 imem_req  output  1  instruction-memory read request.
REQ-008 imem_addr  output  32  instruction-memory read address.
REQ-009 imem_ack  input  1  memory read data valid this cycle.
REQ-010 imem_rdata  input  32  memory read data.
REQ-011 instr  output  32  registered instruction word to decode.
REQ-012 instr_valid  output  1  instr and pc hold a valid instruction.
REQ-013 instr_ready  input  1  downstream accepts instr this cycle.
REQ-014 fetch_err  output  1  misaligned next_pc detected; sticky.
REQ-015 fetch_count  output  32  number of instructions accepted.

Function
REQ-016 FSM states: IDLE, FETCH, VALID, ERROR.
REQ-017 IDLE -> FETCH unconditionally on the first clock edge after rst_n deasserts.
REQ-018 FETCH: imem_req=1, imem_addr=pc; on imem_ack=1, instr <= imem_rdata and state -> VALID; otherwise stay in FETCH with pc, imem_addr stable.
REQ-019 imem_ack is ignored in IDLE, VALID and ERROR; imem_req=0 in those states.
REQ-020 VALID: instr_valid=1, instr and pc held stable until the handshake.
REQ-021 Handshake: transfer when instr_valid=1 and instr_ready=1 in the same cycle; instr_ready while instr_valid=0 has no effect.
REQ-022 On transfer: pc <= next_pc, fetch_count <= fetch_count + 1 (mod 2^32, wrap from FFFF_FFFF to 0).
REQ-023 On transfer with next_pc[1:0] = 2'b00: state -> FETCH; minimum instruction period is 2 cycles (ack cycle plus accept cycle).
REQ-024 On transfer with next_pc[1:0] != 2'b00: state -> ERROR, pc still loaded with next_pc.
REQ-025 ERROR: fetch_err=1, instr_valid=0, imem_req=0; exit only by reset.
REQ-026 pc_plus = pc + 4, 32-bit truncated; FFFF_FFFC yields 0000_0000.
REQ-027 instr_valid deasserts in the cycle after transfer; no back-to-back valid without a new fetch.

Reset
REQ-028 While rst_n=0: pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_err=0, fetch_count=0, state=IDLE.
REQ-029 Reset asserted mid-fetch or mid-handshake abandons the operation immediately; an ack arriving during reset is discarded.

Structure
REQ-030 FSM state encoding and the 32'd4 instruction-size constant live in the shared CPU package.
REQ-031 Single flat module; no sub-modules; the FSM and the PC register in one always block with async reset.

Verification
REQ-032 Reset release, imem_ack=1 in the second cycle, imem_rdata=32'h2008_0005 -> imem_addr=0, then instr=2008_0005, instr_valid=1, pc_plus=4.
REQ-033 Sequential: next_pc=pc_plus, instr_ready=1 held, ack immediate -> pc walks 0,4,8,C; fetch_count=4 after four accepts.
REQ-034 Ack delayed 3 cycles -> imem_req held, imem_addr stable, instr_valid=0 until the ack.
REQ-035 instr_ready=0 for 5 cycles in VALID -> instr and pc unchanged; accept with next_pc=32'h0000_0040 -> next imem_addr=40.
REQ-036 Accept with next_pc=32'h0000_0042 -> fetch_err=1, imem_req=0 forever; rst_n pulse clears to pc=RESET_PC.
REQ-037 rst_n asserted during FETCH with ack in the same cycle -> instr_valid stays 0, pc=RESET_PC, fetch_count=0.
